// File: rtl/range_sample_framer.sv
// FIFO-buffered frame burster: collects samples, then replays one frame per burst with go/finish markers.
// Optional idle-timeout flush is enabled by defining FRAMER_AUTOFLUSH_EN.
module range_sample_framer #(
    parameter int WIDTH     = 8,
    parameter int FRAME_LEN = 16,
    parameter int DEPTH     = 32,
    parameter int TIMEOUT   = 64
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             flush,
    output logic [WIDTH-1:0] out_data,
    output logic             out_go,
    output logic             out_finish,
    output logic             out_active,
    output logic             overflow_err
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FRAME_C = CW'(FRAME_LEN);
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0] TWO_C   = CW'(2);

    if (FRAME_LEN < 2 || FRAME_LEN > DEPTH || (1 << AW) != DEPTH || TIMEOUT < 1) begin : g_bad_cfg
        $error("range_sample_framer: illegal parameter combination");
    end

    typedef enum logic [1:0] {COLLECT, BURST, GAP} state_t;

    state_t           state_q, state_d;
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d, left_q, left_d;
    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic             out_go_q, out_go_d, out_finish_q, out_finish_d;
    logic             out_active_q, out_active_d, overflow_err_q, overflow_err_d;
    logic [WIDTH-1:0] mem [DEPTH];

    logic full, push, pop, start, flush_req;

    assign full     = (count_q == DEPTH_C);
    assign in_ready = !full;
    assign push     = in_valid && !full;

`ifdef FRAMER_AUTOFLUSH_EN
    localparam int IW = $clog2(TIMEOUT + 1);
    logic [IW-1:0] idle_q, idle_d;

    // Idle time only accumulates while a flushable partial frame is waiting.
    always_comb begin
        idle_d = '0;
        if (state_q == COLLECT && count_q >= TWO_C && !push && !start)
            idle_d = idle_q + 1'b1;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) idle_q <= '0;
        else        idle_q <= idle_d;
    end

    assign flush_req = flush || (idle_q == IW'(TIMEOUT));
`else
    assign flush_req = flush;
`endif

    // Count can exceed FRAME_LEN when samples arrive during a burst, hence >=.
    assign start = (state_q == COLLECT) &&
                   (count_q >= FRAME_C || (flush_req && count_q >= TWO_C));
    assign pop   = start || (state_q == BURST);

    always_comb begin
        state_d        = state_q;
        left_d         = left_q;
        out_data_d     = out_data_q;
        out_go_d       = 1'b0;
        out_finish_d   = 1'b0;
        out_active_d   = 1'b0;
        overflow_err_d = overflow_err_q || (in_valid && full);
        wr_ptr_d       = wr_ptr_q + AW'(push);
        rd_ptr_d       = rd_ptr_q + AW'(pop);
        count_d        = count_q + CW'(push) - CW'(pop);
        case (state_q)
            COLLECT: begin
                if (start) begin
                    out_go_d     = 1'b1;
                    out_active_d = 1'b1;
                    out_data_d   = mem[rd_ptr_q];
                    left_d       = ((count_q >= FRAME_C) ? FRAME_C : count_q) - CW'(1);
                    state_d      = BURST;
                end
            end
            BURST: begin
                out_active_d = 1'b1;
                out_data_d   = mem[rd_ptr_q];
                if (left_q == CW'(1)) begin
                    out_finish_d = 1'b1;
                    state_d      = GAP;
                end
                left_d = left_q - CW'(1);
            end
            default: state_d = COLLECT;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q        <= COLLECT;
            wr_ptr_q       <= '0;
            rd_ptr_q       <= '0;
            count_q        <= '0;
            left_q         <= '0;
            out_data_q     <= '0;
            out_go_q       <= 1'b0;
            out_finish_q   <= 1'b0;
            out_active_q   <= 1'b0;
            overflow_err_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            wr_ptr_q       <= wr_ptr_d;
            rd_ptr_q       <= rd_ptr_d;
            count_q        <= count_d;
            left_q         <= left_d;
            out_data_q     <= out_data_d;
            out_go_q       <= out_go_d;
            out_finish_q   <= out_finish_d;
            out_active_q   <= out_active_d;
            overflow_err_q <= overflow_err_d;
        end
    end

    // Storage carries no reset so it maps onto plain RAM.
    always_ff @(posedge clock) begin
        if (push) mem[wr_ptr_q] <= in_data;
    end

    assign out_data     = out_data_q;
    assign out_go       = out_go_q;
    assign out_finish   = out_finish_q;
    assign out_active   = out_active_q;
    assign overflow_err = overflow_err_q;
endmodule

// File: tb/tb_range_sample_framer.sv
// Bench for range_sample_framer: queue-based reference model plus scenario tasks.
module tb_range_sample_framer;
    localparam int WIDTH = 8, FL = 16, DEPTH = 32, TIMEOUT = 64;

    logic clock = 1'b0;
    logic reset = 1'b0;
    always #5 clock = ~clock;

    logic [7:0] in_data = '0;
    logic       in_valid = 1'b0, flush = 1'b0;
    logic [7:0] out_data;
    logic       in_ready, out_go, out_finish, out_active, overflow_err;

    logic [7:0] d_data = '0;
    logic       d_valid = 1'b0, d_flush = 1'b0;
    logic [7:0] d_out;
    logic       d_ready, d_go, d_fin, d_act, d_ovf;

    range_sample_framer #(.WIDTH(WIDTH), .FRAME_LEN(FL), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
        .clock(clock), .reset(reset), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .flush(flush), .out_data(out_data), .out_go(out_go), .out_finish(out_finish),
        .out_active(out_active), .overflow_err(overflow_err));

    range_sample_framer #(.WIDTH(8), .FRAME_LEN(32), .DEPTH(32), .TIMEOUT(64)) dut32 (
        .clock(clock), .reset(reset), .in_data(d_data), .in_valid(d_valid), .in_ready(d_ready),
        .flush(d_flush), .out_data(d_out), .out_go(d_go), .out_finish(d_fin),
        .out_active(d_act), .overflow_err(d_ovf));

    int checks = 0, errors = 0;

    // Reference model: a sample queue plus "samples left in burst" and "gap pending".
    logic [7:0] mq[$];
    int         m_left, m_idle, m_pre;
    bit         m_gap, m_acc, m_fl, m_started, m_collect;
    logic [7:0] m_data;
    logic       m_go, m_fin, m_act, m_ovf, m_rdy;

    always @(posedge clock or negedge reset) begin
        if (!reset) begin
            mq.delete();
            m_left = 0; m_idle = 0; m_gap = 0;
            m_data = '0; m_go = 0; m_fin = 0; m_act = 0; m_ovf = 0; m_rdy = 1;
        end else begin
            m_pre     = mq.size();
            m_acc     = in_valid && (m_pre < DEPTH);
            m_fl      = flush;
`ifdef FRAMER_AUTOFLUSH_EN
            m_fl      = m_fl || (m_idle == TIMEOUT);
`endif
            m_collect = !m_gap && (m_left == 0);
            m_started = 0;
            if (in_valid && !m_acc) m_ovf = 1;
            m_go = 0; m_fin = 0; m_act = 0;
            if (m_gap) begin
                m_gap = 0;
            end else if (m_left > 0) begin
                m_data = mq.pop_front(); m_act = 1; m_left--;
                if (m_left == 0) begin m_fin = 1; m_gap = 1; end
            end else if (m_pre >= FL || (m_fl && m_pre >= 2)) begin
                m_left = (m_pre < FL) ? m_pre : FL;
                m_data = mq.pop_front(); m_act = 1; m_go = 1; m_left--; m_started = 1;
            end
            m_idle = (m_collect && !m_started && !m_acc && m_pre >= 2) ? m_idle + 1 : 0;
            if (m_acc) mq.push_back(in_data);
            m_rdy = (mq.size() < DEPTH);
        end
    end

    wire [12:0] dut_vec = {out_active, out_go, out_finish, out_data, in_ready, overflow_err};
    wire [12:0] mdl_vec = {m_act, m_go, m_fin, m_data, m_rdy, m_ovf};

    task automatic do_reset();
        reset = 1'b0; in_valid = 0; flush = 0; d_valid = 0; d_flush = 0;
        @(negedge clock); @(negedge clock);
        reset = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (dut_vec !== 13'h002) begin
            errors++; $display("FAIL reset got=%h exp=%h", dut_vec, 13'h002);
        end
        checks++;
        if ({d_act, d_go, d_fin, d_out, d_ready, d_ovf} !== 13'h002) begin
            errors++; $display("FAIL reset32 got=%h exp=%h", {d_act, d_go, d_fin, d_out, d_ready, d_ovf}, 13'h002);
        end
    endtask

    task automatic test_full_frame();
        do_reset();
        for (int i = 0; i < 36; i++) begin
            in_valid = (i < 16); in_data = 8'(8'h10 + i);
            @(negedge clock);
            checks++;
            if (dut_vec !== mdl_vec) begin
                errors++; $display("FAIL full_frame cyc=%0d got=%h exp=%h", i, dut_vec, mdl_vec);
            end
            if (i == 16 || i == 31 || i == 32) begin
                checks++;
                if ({out_go, out_finish, out_active, out_data} !==
                    ((i == 16) ? 11'h5_10 : (i == 31) ? 11'h3_1F : 11'h0_1F)) begin
                    errors++; $display("FAIL full_frame_edge cyc=%0d got=%h", i, {out_go, out_finish, out_active, out_data});
                end
            end
        end
    endtask

    task automatic test_flush_partial();
        do_reset();
        for (int s = 0; s < 5; s++) begin
            int gap = $urandom_range(0, 3);
            for (int g = 0; g <= gap; g++) begin
                in_valid = (g == gap); in_data = 8'($urandom);
                @(negedge clock);
                checks++;
                if (dut_vec !== mdl_vec) begin
                    errors++; $display("FAIL flush_partial s=%0d got=%h exp=%h", s, dut_vec, mdl_vec);
                end
            end
        end
        in_valid = 0;
        for (int i = 0; i < 10; i++) begin
            flush = (i == 0);
            @(negedge clock);
            checks++;
            if (dut_vec !== mdl_vec) begin
                errors++; $display("FAIL flush_partial burst cyc=%0d got=%h exp=%h", i, dut_vec, mdl_vec);
            end
            if (i == 0 || i == 4) begin
                checks++;
                if ((i == 0 && out_go !== 1'b1) || (i == 4 && out_finish !== 1'b1)) begin
                    errors++; $display("FAIL flush_partial_marker cyc=%0d go=%b fin=%b", i, out_go, out_finish);
                end
            end
        end
        flush = 0;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++; $display("FAIL flush_partial_ready got=%b exp=1", in_ready);
        end
    endtask

    task automatic test_flush_ignored();
        logic [7:0] first;
        int go_seen = 0;
        do_reset();
        first = 8'($urandom);
        for (int i = 0; i < 40; i++) begin
            in_valid = (i == 0) || (i >= 2 && i < 17);
            in_data  = (i == 0) ? first : 8'($urandom);
            flush    = (i == 1);
            @(negedge clock);
            checks++;
            if (dut_vec !== mdl_vec) begin
                errors++; $display("FAIL flush_ignored cyc=%0d got=%h exp=%h", i, dut_vec, mdl_vec);
            end
            if (out_go === 1'b1) begin
                go_seen++;
                checks++;
                if (out_data !== first || i != 17) begin
                    errors++; $display("FAIL flush_ignored_first cyc=%0d got=%h exp=%h at cyc 17", i, out_data, first);
                end
            end
        end
        flush = 0; in_valid = 0;
        checks++;
        if (go_seen != 1) begin
            errors++; $display("FAIL flush_ignored_bursts got=%0d exp=1", go_seen);
        end
    endtask

    task automatic test_overflow32();
        logic [7:0] arr [33];
        do_reset();
        for (int i = 0; i < 33; i++) arr[i] = 8'($urandom);
        for (int i = 0; i < 33; i++) begin
            d_valid = 1; d_data = arr[i];
            @(negedge clock);
            checks++;
            if (i < 31 && {d_act, d_ovf, d_ready} !== 3'b001) begin
                errors++; $display("FAIL ovf32_fill cyc=%0d act/ovf/rdy got=%b exp=001", i, {d_act, d_ovf, d_ready});
            end else if (i == 31 && {d_act, d_ovf, d_ready} !== 3'b000) begin
                errors++; $display("FAIL ovf32_full got=%b exp=000", {d_act, d_ovf, d_ready});
            end else if (i == 32 && {d_go, d_ovf, d_out} !== {2'b11, arr[0]}) begin
                errors++; $display("FAIL ovf32_go got=%h exp=%h", {d_go, d_ovf, d_out}, {2'b11, arr[0]});
            end
        end
        d_valid = 0;
        for (int k = 1; k < 33; k++) begin
            @(negedge clock);
            checks++;
            if (k < 32 && {d_act, d_go, d_fin, d_ovf, d_out} !== {3'b100, 1'b1, arr[k]} && k != 31) begin
                errors++; $display("FAIL ovf32_burst k=%0d got=%h exp=%h", k, {d_act, d_go, d_fin, d_ovf, d_out}, {4'b1001, arr[k]});
            end else if (k == 31 && {d_act, d_go, d_fin, d_ovf, d_out} !== {4'b1011, arr[31]}) begin
                errors++; $display("FAIL ovf32_finish got=%h exp=%h", {d_act, d_go, d_fin, d_ovf, d_out}, {4'b1011, arr[31]});
            end else if (k == 32 && {d_act, d_ovf, d_ready} !== 3'b011) begin
                errors++; $display("FAIL ovf32_gap act/ovf/rdy got=%b exp=011", {d_act, d_ovf, d_ready});
            end
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        for (int rep = 0; rep < 4; rep++) begin
            int fill = (rep == 0) ? 16 : 12;
            for (int i = 0; i < fill + 19; i++) begin
                in_valid = (i < fill) || (i >= fill + 1 && i < fill + 5);
                in_data  = 8'($urandom);
                @(negedge clock);
                checks++;
                if (dut_vec !== mdl_vec) begin
                    errors++; $display("FAIL back_to_back rep=%0d cyc=%0d got=%h exp=%h", rep, i, dut_vec, mdl_vec);
                end
            end
        end
        in_valid = 0;
    endtask

    task automatic test_autoflush();
        int go_at = -1;
        do_reset();
        for (int i = 0; i < 3 + 80; i++) begin
            in_valid = (i < 3); in_data = 8'($urandom);
            @(negedge clock);
            checks++;
            if (dut_vec !== mdl_vec) begin
                errors++; $display("FAIL autoflush cyc=%0d got=%h exp=%h", i, dut_vec, mdl_vec);
            end
            if (out_go === 1'b1 && go_at < 0) go_at = i - 2;
        end
        in_valid = 0;
        checks++;
`ifdef FRAMER_AUTOFLUSH_EN
        if (go_at != 65) begin
            errors++; $display("FAIL autoflush_delay got=%0d exp=65", go_at);
        end
`else
        if (go_at != -1) begin
            errors++; $display("FAIL autoflush_none got go at %0d exp none", go_at);
        end
`endif
    endtask

    task automatic test_reset_midburst();
        do_reset();
        for (int i = 0; i < 20; i++) begin
            in_valid = (i < 16); in_data = 8'($urandom);
            @(negedge clock);
        end
        in_valid = 0;
        #2 reset = 1'b0;
        #1;
        checks++;
        if (dut_vec !== 13'h002) begin
            errors++; $display("FAIL reset_midburst got=%h exp=%h", dut_vec, 13'h002);
        end
        @(negedge clock); reset = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clock);
            checks++;
            if (dut_vec !== mdl_vec || out_finish !== 1'b0) begin
                errors++; $display("FAIL reset_midburst_after cyc=%0d got=%h exp=%h", i, dut_vec, mdl_vec);
            end
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 600; i++) begin
            in_valid = ($urandom_range(0, 3) != 0);
            in_data  = 8'($urandom);
            flush    = ($urandom_range(0, 7) == 0);
            @(negedge clock);
            checks++;
            if (dut_vec !== mdl_vec) begin
                errors++; $display("FAIL random cyc=%0d got=%h exp=%h", i, dut_vec, mdl_vec);
            end
        end
        in_valid = 0; flush = 0;
    endtask

    initial begin
        test_reset();
        test_full_frame();
        test_flush_partial();
        test_flush_ignored();
        test_overflow32();
        test_back_to_back();
        test_autoflush();
        test_reset_midburst();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
